crc8_ser: RTL and testbench
===========================

CRC8_SER -- requirements
Module: crc8_ser

Interface
REQ-001 SHALL have parameter POLY, default 8'h07, CRC-8 generator polynomial with the implicit x^8 term omitted.
REQ-002 SHALL have parameter INIT, default 8'h00, CRC register preset value loaded at reset and at start of frame.
REQ-003 SHALL have port CK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RN, input, 1 bit, reset; synchronous, active-low.
REQ-005 SHALL have port DIN, input, 1 bit, serial data bit, MSB-first.
REQ-006 SHALL have port DV, input, 1 bit, DIN valid qualifier.
REQ-007 SHALL have port SOF, input, 1 bit, marks the first bit of a frame; qualified by DV.
REQ-008 SHALL have port EOF, input, 1 bit, marks the last bit of a frame; qualified by DV.
REQ-009 SHALL have port CRC, output, 8 bits, current CRC register value.
REQ-010 SHALL have port CRCV, output, 1 bit, one-cycle pulse meaning CRC holds the final frame result.
REQ-011 SHALL have port BUSY, output, 1 bit, high while a frame is open.
REQ-012 SHALL have port BITCNT, output, 16 bits, number of bits accepted in the current or last frame; saturates at 16'hFFFF.
REQ-013 SHALL have port BYTEOK, output, 1 bit, high when the last completed frame length was a nonzero multiple of 8.

Function
REQ-014 SHALL implement states IDLE, ACC and DONE.
REQ-015 SHALL define one step as: fb = CRC[7] XOR DIN; CRC_next = {CRC[6:0],1'b0} XOR (fb ? POLY : 8'h00).
REQ-016 SHALL, on DV=1 and SOF=1 in any state, apply one step to INIT (not to the old CRC), set BITCNT=1 and enter ACC; this aborts any open frame without a CRCV pulse.
REQ-017 SHALL, in ACC with DV=1 and SOF=0, apply one step to CRC and increment BITCNT.
REQ-018 SHALL, on any accepted bit with EOF=1, enter DONE; CRCV=1 in the following cycle only, after which the state returns to IDLE.
REQ-019 SHALL treat SOF=1 and EOF=1 in the same DV cycle as a one-bit frame: step from INIT, BITCNT=1, enter DONE.
REQ-020 SHALL hold CRC, BITCNT and state unchanged in any cycle with DV=0.
REQ-021 SHALL ignore DV=1 with SOF=0 in IDLE or DONE: no step and no count change.
REQ-022 SHALL register CRCV, BUSY and BYTEOK; BUSY=1 exactly while the state is ACC.
REQ-023 SHALL update BYTEOK only on entry to DONE, computed as (BITCNT_final[2:0]==0) with BITCNT_final nonzero; it holds until the next entry to DONE or reset.
REQ-024 SHALL hold CRC and BITCNT after DONE until the next SOF.

Reset
REQ-025 SHALL, on RN=0 at a rising CK, set state IDLE, CRC=INIT, BITCNT=0, CRCV=0, BUSY=0 and BYTEOK=0, overriding all other inputs.
REQ-026 SHALL abandon a frame silently when reset occurs mid-frame, with no CRCV pulse.

Configuration
REQ-027 SHALL provide macro CRC8_SER_REFOUT_EN.
REQ-028 SHALL, with CRC8_SER_REFOUT_EN defined, drive CRC as the bit-reversed internal register (CRC[i] = reg[7-i]); the internal computation is unchanged.
REQ-029 SHALL, without CRC8_SER_REFOUT_EN defined, drive CRC directly from the internal register.

Verification
REQ-030 SHALL cover: defaults, frame 8'h01 MSB-first (SOF on first bit, EOF on last) -> CRCV pulse one cycle after the EOF bit, CRC=8'h07, BITCNT=8, BYTEOK=1.
REQ-031 SHALL cover: defaults, ASCII "123456789" (72 bits) with random DV gaps -> CRC=8'hF4, BITCNT=72, BYTEOK=1, BUSY low after DONE.
REQ-032 SHALL cover: defaults, frame 8'h80 aborted after 4 bits by a new SOF, then frame 8'h80 sent in full -> no CRCV pulse for the aborted frame, then CRC=8'h89, BITCNT=8.
REQ-033 SHALL cover: one-bit frame DIN=1 with SOF=EOF=1 -> CRC=8'h07, BITCNT=1, BYTEOK=0.
REQ-034 SHALL cover: RN=0 mid-frame -> next cycle CRC=8'h00, BITCNT=0, BUSY=0, no CRCV pulse; also DV=1 in IDLE without SOF -> no change.
REQ-035 SHALL cover: with CRC8_SER_REFOUT_EN defined, frame 8'h01 -> CRC=8'hE0.

Source files
------------

// File: rtl/crc8_ser.sv
// Bit-serial CRC-8 engine with SOF/EOF framing, bit counter and byte-alignment flag.
// Define CRC8_SER_REFOUT_EN to present CRC bit-reversed; the internal register is unaffected.
module crc8_ser #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic        CK,
  input  logic        RN,
  input  logic        DIN,
  input  logic        DV,
  input  logic        SOF,
  input  logic        EOF,
  output logic [7:0]  CRC,
  output logic        CRCV,
  output logic        BUSY,
  output logic [15:0] BITCNT,
  output logic        BYTEOK
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  crc_r, crc_s;
  logic [15:0] bitcnt_r, bitcnt_s;
  logic        byteok_r, byteok_s;
  logic        crcv_r;
  logic        busy_r;

  function automatic logic [7:0] crc_step(input logic [7:0] cur, input logic bit_in);
    logic fb;
    fb = cur[7] ^ bit_in;
    return {cur[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  endfunction

  function automatic logic [7:0] bit_rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7 - i];
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : (v + 16'd1);
  endfunction

  // Next-state logic: SOF restarts from INIT in any state; DONE lasts exactly one cycle.
  always_comb begin
    state_s  = state_r;
    crc_s    = crc_r;
    bitcnt_s = bitcnt_r;
    byteok_s = byteok_r;
    if (DV && SOF) begin
      crc_s    = crc_step(INIT, DIN);
      bitcnt_s = 16'd1;
      if (EOF) begin
        state_s  = DONE;
        byteok_s = 1'b0;
      end else begin
        state_s  = ACC;
      end
    end else begin
      case (state_r)
        ACC: begin
          if (DV) begin
            crc_s    = crc_step(crc_r, DIN);
            bitcnt_s = sat_inc16(bitcnt_r);
            if (EOF) begin
              state_s  = DONE;
              byteok_s = (bitcnt_s[2:0] == 3'd0) && (bitcnt_s != 16'd0);
            end else begin
              state_s  = ACC;
            end
          end else begin
            state_s = ACC;
          end
        end
        DONE:    state_s = IDLE;
        IDLE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State and result registers; status flags are registered from the next state.
  always_ff @(posedge CK) begin
    if (!RN) begin
      state_r  <= IDLE;
      crc_r    <= INIT;
      bitcnt_r <= 16'd0;
      byteok_r <= 1'b0;
      crcv_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      crc_r    <= crc_s;
      bitcnt_r <= bitcnt_s;
      byteok_r <= byteok_s;
      crcv_r   <= (state_s == DONE);
      busy_r   <= (state_s == ACC);
    end
  end

`ifdef CRC8_SER_REFOUT_EN
  assign CRC = bit_rev8(crc_r);
`else
  assign CRC = crc_r;
`endif
  assign CRCV   = crcv_r;
  assign BUSY   = busy_r;
  assign BITCNT = bitcnt_r;
  assign BYTEOK = byteok_r;

endmodule

// File: tb/tb_crc8_ser.sv
// Self-checking bench for crc8_ser: directed frame table, abort/reset sequences,
// and random frames checked against a polynomial long-division reference.
module tb_crc8_ser;

  logic        CK = 1'b0;
  logic        RN, DIN, DV, SOF, EOF;
  logic [7:0]  CRC;
  logic        CRCV, BUSY, BYTEOK;
  logic [15:0] BITCNT;

  int checks = 0;
  int failures = 0;
  int crcv_cnt = 0;
  bit fq[$];

  typedef struct {
    logic [71:0] data;
    int          len;
    logic [7:0]  crc;
    logic        byteok;
  } vec_t;

  crc8_ser dut (
    .CK(CK), .RN(RN), .DIN(DIN), .DV(DV), .SOF(SOF), .EOF(EOF),
    .CRC(CRC), .CRCV(CRCV), .BUSY(BUSY), .BITCNT(BITCNT), .BYTEOK(BYTEOK)
  );

  always #5 CK = ~CK;

  always @(negedge CK) begin
    if (CRCV === 1'b1) crcv_cnt++;
  end

  function automatic logic [7:0] omap(input logic [7:0] v);
    logic [7:0] r;
`ifdef CRC8_SER_REFOUT_EN
    for (int i = 0; i < 8; i++) r[i] = v[7 - i];
`else
    r = v;
`endif
    return r;
  endfunction

  // Remainder of (message * x^8) divided by x^8 + POLY, with INIT = 0.
  function automatic logic [7:0] model_crc();
    logic [7:0] r;
    logic       top;
    bit         ext[$];
    r = 8'h00;
    ext = fq;
    for (int k = 0; k < 8; k++) ext.push_back(1'b0);
    foreach (ext[k]) begin
      top = r[7];
      r = {r[6:0], ext[k]};
      if (top) r = r ^ 8'h07;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic idle_in();
    DV = 1'b0; SOF = 1'b0; EOF = 1'b0; DIN = 1'b0;
  endtask

  task automatic load_fq(input logic [71:0] data, input int len);
    fq.delete();
    for (int b = len - 1; b >= 0; b--) fq.push_back(data[b]);
  endtask

  task automatic send_frame(input int gap_max, input bit with_eof,
                            input logic [7:0] exp_crc, input logic exp_byteok);
    int n;
    int c0;
    logic [7:0] crc_hold;
    n = fq.size();
    c0 = crcv_cnt;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        DV = 1'b0; DIN = 1'($urandom); SOF = 1'($urandom); EOF = 1'($urandom);
        tick();
        if (i > 0) begin
          chk("gap_hold_bitcnt", BITCNT, i);
          chk("gap_busy", BUSY, 1'b1);
        end
      end
      DV = 1'b1; DIN = fq[i]; SOF = (i == 0); EOF = with_eof && (i == n - 1);
      tick();
      chk("bitcnt_run", BITCNT, i + 1);
    end
    idle_in();
    if (with_eof) begin
      chk("crcv_pulse", CRCV, 1'b1);
      chk("crc_final", CRC, omap(exp_crc));
      chk("bitcnt_final", BITCNT, n);
      chk("byteok_final", BYTEOK, exp_byteok);
      chk("busy_done", BUSY, 1'b0);
      crc_hold = CRC;
      tick();
      chk("crcv_one_cycle", CRCV, 1'b0);
      chk("crc_held", CRC, crc_hold);
      chk("bitcnt_held", BITCNT, n);
      chk("crcv_count", crcv_cnt - c0, 1);
    end else begin
      chk("busy_open", BUSY, 1'b1);
    end
  endtask

  initial begin
    vec_t tbl[5];
    int   c0;
    int   len;
    logic [71:0] rnd;

    tbl[0] = '{72'h01, 8, 8'h07, 1'b1};
    tbl[1] = '{72'h80, 8, 8'h89, 1'b1};
    tbl[2] = '{72'h01, 1, 8'h07, 1'b0};
    tbl[3] = '{72'hFF, 8, 8'hF3, 1'b1};
    tbl[4] = '{72'h313233343536373839, 72, 8'hF4, 1'b1};

    RN = 1'b0;
    idle_in();
    tick();
    tick();
    chk("rst_crc", CRC, omap(8'h00));
    chk("rst_bitcnt", BITCNT, 16'd0);
    chk("rst_crcv", CRCV, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_byteok", BYTEOK, 1'b0);
    RN = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      load_fq(tbl[v].data, tbl[v].len);
      send_frame(3, 1'b1, tbl[v].crc, tbl[v].byteok);
      tick();
    end

    // DV without SOF in IDLE must not step or count.
    c0 = crcv_cnt;
    repeat (3) begin
      DV = 1'b1; SOF = 1'b0; EOF = 1'b1; DIN = 1'($urandom);
      tick();
    end
    idle_in();
    chk("idle_dv_bitcnt", BITCNT, 16'd72);
    chk("idle_dv_crc", CRC, omap(8'hF4));
    chk("idle_dv_busy", BUSY, 1'b0);
    chk("idle_dv_crcv", crcv_cnt - c0, 0);

    // Abort 0x80 after 4 bits with a fresh SOF, then send it in full.
    c0 = crcv_cnt;
    load_fq(72'h8, 4);
    send_frame(1, 1'b0, 8'h00, 1'b0);
    load_fq(72'h80, 8);
    send_frame(1, 1'b1, 8'h89, 1'b1);
    chk("abort_crcv_total", crcv_cnt - c0, 1);

    // Random frames against the long-division reference.
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 40);
      rnd = {$urandom, $urandom, $urandom};
      load_fq(rnd, len);
      send_frame(2, 1'b1, model_crc(), (len % 8) == 0);
    end

    // Reset mid-frame abandons the frame silently.
    c0 = crcv_cnt;
    load_fq(72'hB, 4);
    send_frame(0, 1'b0, 8'h00, 1'b0);
    RN = 1'b0; DV = 1'b1; SOF = 1'b1; EOF = 1'b1; DIN = 1'b1;
    tick();
    chk("midrst_crc", CRC, omap(8'h00));
    chk("midrst_bitcnt", BITCNT, 16'd0);
    chk("midrst_busy", BUSY, 1'b0);
    chk("midrst_crcv", CRCV, 1'b0);
    chk("midrst_byteok", BYTEOK, 1'b0);
    RN = 1'b1;
    repeat (3) begin
      DV = 1'b1; SOF = 1'b0; EOF = 1'b0; DIN = 1'b1;
      tick();
    end
    idle_in();
    tick();
    chk("postrst_bitcnt", BITCNT, 16'd0);
    chk("postrst_crc", CRC, omap(8'h00));
    chk("postrst_busy", BUSY, 1'b0);
    chk("midrst_crcv_total", crcv_cnt - c0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
